avalon_arbiter: RTL
===================

AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 Parameter N_PORTS, 2, number of Avalon-MM masters sharing one slave (legal 2..8).
REQ-002 Parameter ADDR_W, 25, address width.
REQ-003 Parameter DATA_W, 16, data width; byte-enable width BE_W = DATA_W/8.
REQ-004 Parameter TAG_DEPTH, 8, max outstanding reads (power of 2, 2..32).
REQ-005 Derived IDX_W = clog2(N_PORTS); CNT_W = clog2(TAG_DEPTH)+1.
REQ-006 Clk  input  1  single clock; all logic rising-edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 Mode  input  2  0 = round-robin, 1 = fixed priority (port 0 highest), 2 = locked to Select, 3 = treated as 0.
REQ-009 Select  input  IDX_W  port owning the slave in mode 2.
REQ-010 M_ChipSelect, M_Write, M_Read  input  N_PORTS each  per-master strobes.
REQ-011 M_Address, M_ByteEnable, M_WriteData  input  N_PORTS*ADDR_W, N_PORTS*BE_W, N_PORTS*DATA_W  flattened; port i at slice i.
REQ-012 M_WaitRequest, M_ReadDataValid  output  N_PORTS each  per-master responses.
REQ-013 M_ReadData  output  N_PORTS*DATA_W  flattened per-master read data.
REQ-014 S_ChipSelect, S_Write, S_Read  output  1 each  to slave.
REQ-015 S_Address, S_ByteEnable, S_WriteData  output  ADDR_W, BE_W, DATA_W  to slave.
REQ-016 S_WaitRequest, S_ReadDataValid  input  1 each; S_ReadData  input  DATA_W.
REQ-017 Owner  output  IDX_W  current grant; Owner_Valid  output  1  grant held.
REQ-018 Outstanding  output  CNT_W  reads in flight; Error  output  1  sticky spurious-readdatavalid flag.

Function
REQ-019 Request of port i = M_ChipSelect[i] & (M_Write[i] | M_Read[i]).
REQ-020 Two states: IDLE (Owner_Valid=0) and OWNED (Owner_Valid=1, Owner registered).
REQ-021 IDLE with any request -> OWNED with winner next edge; grant latency 1 cycle; no requests -> stay IDLE.
REQ-022 Winner: mode 0 first requester searching upward cyclically from last-owner+1; mode 1 lowest-index requester; mode 2 Select if requesting, else none.
REQ-023 OWNED: slave outputs driven combinationally from Owner's slice; S_* strobes forced 0 in IDLE.
REQ-024 Accept = OWNED & owner request & ~S_WaitRequest & ~(owner read & tag FIFO full).
REQ-025 On accept, or owner request deasserted, Owner re-registers at same edge to next winner (round-robin pointer advances past current owner); no winner -> IDLE; back-to-back transfers from different ports have zero idle cycles.
REQ-026 Mode/Select changes take effect only at next arbitration (REQ-021/025), never mid-transfer.
REQ-027 M_WaitRequest[i] = 0 only for the owner on an accept cycle; 1 otherwise, including IDLE.
REQ-028 Tag FIFO full: S_Read, S_ChipSelect forced 0 for owner read; owner writes unaffected.
REQ-029 Each accepted read pushes Owner index into tag FIFO (depth TAG_DEPTH).
REQ-030 S_ReadDataValid with FIFO non-empty pops head; M_ReadDataValid[head]=1, M_ReadData[head]=S_ReadData same cycle; all other ports' readdata 0, readdatavalid 0.
REQ-031 Push and pop same cycle: both occur, Outstanding unchanged; push when full is impossible (REQ-028) even if pop occurs that cycle.
REQ-032 S_ReadDataValid with FIFO empty: data discarded, no M_ReadDataValid, Error set until reset.
REQ-033 Outstanding = FIFO occupancy, 0..TAG_DEPTH, registered.

Reset
REQ-034 Reset_n low asynchronously: state IDLE, Owner=0, RR pointer=N_PORTS-1 (port 0 wins first), FIFO empty, Outstanding=0, Error=0, all M_WaitRequest=1, M_ReadDataValid=0, M_ReadData=0, S_* strobes 0.
REQ-035 Reset mid-transfer abandons in-flight reads; read data arriving after release raises Error per REQ-032.

Verification
REQ-036 N=2, mode 0, both ports continuously write, slave waitrequest 0 -> grants alternate 0,1,0,1 each cycle after 1-cycle initial latency.
REQ-037 N=4, mode 1, ports 1 and 3 requesting -> port 1 served every transfer, port 3 M_WaitRequest stays 1 until port 1 drops.
REQ-038 Mode 0, reads from ports 0,2,1 accepted, slave returns 3 words after 5 cycles -> M_ReadDataValid pulses on 0,2,1 in order with matching data.
REQ-039 TAG_DEPTH=4, 5 reads issued, no readdatavalid -> Outstanding=4, 5th read stalled with S_Read=0; one return -> 5th accepted next cycle.
REQ-040 S_ReadDataValid with Outstanding=0 -> no master valid, Error=1 until Reset_n low.
REQ-041 Reset_n low with 2 reads outstanding -> Outstanding=0, Owner_Valid=0 immediately; later return sets Error.

Source files
------------

// File: rtl/avalon_arbiter.sv
// Avalon-MM N-master to 1-slave arbiter with round-robin / fixed / locked grant
// modes and a read-tag FIFO that routes returning read data to its issuer.
module avalon_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 8,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = $clog2(N_PORTS),
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [1:0]                  Mode,
  input  logic [IDX_W-1:0]            Select,
  input  logic [N_PORTS-1:0]          M_ChipSelect,
  input  logic [N_PORTS-1:0]          M_Write,
  input  logic [N_PORTS-1:0]          M_Read,
  input  logic [N_PORTS*ADDR_W-1:0]   M_Address,
  input  logic [N_PORTS*BE_W-1:0]     M_ByteEnable,
  input  logic [N_PORTS*DATA_W-1:0]   M_WriteData,
  output logic [N_PORTS-1:0]          M_WaitRequest,
  output logic [N_PORTS-1:0]          M_ReadDataValid,
  output logic [N_PORTS*DATA_W-1:0]   M_ReadData,
  output logic                        S_ChipSelect,
  output logic                        S_Write,
  output logic                        S_Read,
  output logic [ADDR_W-1:0]           S_Address,
  output logic [BE_W-1:0]             S_ByteEnable,
  output logic [DATA_W-1:0]           S_WriteData,
  input  logic                        S_WaitRequest,
  input  logic                        S_ReadDataValid,
  input  logic [DATA_W-1:0]           S_ReadData,
  output logic [IDX_W-1:0]            Owner,
  output logic                        Owner_Valid,
  output logic [CNT_W-1:0]            Outstanding,
  output logic                        Error
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam bit SEL_FULL = (N_PORTS == (1 << IDX_W));

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   owner, owner_nx, rr_ptr, rr_nx, win_idx;
  logic               win_found;
  logic [N_PORTS-1:0] req;
  logic               owned, own_req, own_rd, blocked, accept, push, pop;

  logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, fifo_empty, err_q;
  logic [IDX_W-1:0]   head;

  always_comb begin
    req        = M_ChipSelect & (M_Write | M_Read);
    owned      = (state == OWNED);
    own_req    = req[owner];
    own_rd     = M_Read[owner];
    fifo_full  = (count == CNT_W'(TAG_DEPTH));
    fifo_empty = (count == '0);
    head       = tag_mem[rd_ptr];
    blocked    = own_rd & fifo_full;
    accept     = owned & own_req & ~S_WaitRequest & ~blocked;
    push       = accept & own_rd;
    pop        = S_ReadDataValid & ~fifo_empty;
  end

  // Winner search; rr_ptr always holds the most recent grant, so the
  // round-robin scan starting at rr_ptr+1 skips the current owner.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    case (Mode)
      2'd1: begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
          if (!win_found && req[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
          end
        end
      end
      2'd2: begin
        if ((SEL_FULL || (32'(Select) < 32'(N_PORTS))) && req[Select]) begin
          win_found = 1'b1;
          win_idx   = Select;
        end
      end
      default: begin
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
          idx = (32'(rr_ptr) + k) % N_PORTS;
          if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(idx);
          end
        end
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    if (!owned || accept || !own_req) begin
      if (win_found) begin
        state_nx = OWNED;
        owner_nx = win_idx;
        rr_nx    = win_idx;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= IDX_W'(N_PORTS - 1);
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (S_ReadDataValid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    S_ChipSelect    = owned & M_ChipSelect[owner] & ~blocked;
    S_Write         = owned & M_Write[owner] & ~blocked;
    S_Read          = owned & M_Read[owner] & ~blocked;
    S_Address       = M_Address[owner*ADDR_W +: ADDR_W];
    S_ByteEnable    = M_ByteEnable[owner*BE_W +: BE_W];
    S_WriteData     = M_WriteData[owner*DATA_W +: DATA_W];
    M_WaitRequest   = '1;
    M_ReadDataValid = '0;
    M_ReadData      = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (accept && owner == IDX_W'(i)) M_WaitRequest[i] = 1'b0;
      if (pop && head == IDX_W'(i)) begin
        M_ReadDataValid[i]                = 1'b1;
        M_ReadData[i*DATA_W +: DATA_W]    = S_ReadData;
      end
    end
  end

  assign Owner       = owner;
  assign Owner_Valid = owned;
  assign Outstanding = count;
  assign Error       = err_q;

endmodule
